frame_buffer: RTL

Double-buffered pixel store between the SPI byte receiver and the LED matrix scanner. It takes whole bytes from the SPI slave, fills a back buffer in scan order, and swaps buffers only at a scanner frame boundary, so the display never tears. The scanner reads the front buffer by (row, column) and gets the packed top/bottom RGB pair for each column of the 32x32 panel (two 16-row halves).

---
 rtl/display_pkg.sv | 30 +++
 rtl/dp_ram.sv | 35 +++
 rtl/frame_buffer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the LED matrix display path.
package display_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 32;
    localparam int PIX_W  = 6;
    localparam int DEPTH  = ROWS * COLS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [7:0] SOF_BYTE = 8'h80;

    // Writer states, kept as plain constants so older code can compare raw bits.
    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;

    typedef enum logic [1:0] {
        WAIT_SOF = ST_WAIT_SOF,
        LOAD     = ST_LOAD,
        FULL     = ST_FULL
    } wr_state_t;

    typedef logic [2:0] rgb_t;

    typedef struct packed {
        rgb_t top;
        rgb_t bot;
    } pix_pair_t;

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module dp_ram
    import display_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = PIX_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; the output register alone is reset so rd_data starts at 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 32x32 panel store between the SPI receiver and the scanner.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   WAIT_SOF | idle, discard everything until a start-of-frame byte
//   LOAD     | filling the back bank in scan order at wptr
//   FULL     | back bank complete, waiting for scanner frame end to swap
module frame_buffer
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic [3:0]       rd_row,
    input  logic [4:0]       rd_col,
    input  logic             rd_frame_end,
    output logic [PIX_W-1:0] rd_data,
    output logic             frame_pending,
    output logic             front_sel,
    output logic             overrun_err
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rd_addr;
    pix_pair_t         wr_pix;
    logic              is_sof;
    logic              is_data;
    logic              wr_en;
    logic              we0;
    logic              we1;
    logic [PIX_W-1:0]  q0;
    logic [PIX_W-1:0]  q1;
    logic              rd_sel_q;

    assign rd_addr = {rd_row, rd_col};
    assign wr_pix  = rx_byte[5:0];
    assign is_sof  = rx_valid && (rx_byte == SOF_BYTE);
    assign is_data = rx_valid && !rx_byte[7];
    assign wr_en   = (state == ST_LOAD) && is_data;

    // Only the back bank is ever written, so reads and writes never collide.
    assign we0 = wr_en && front_sel;
    assign we1 = wr_en && !front_sel;

    dp_ram u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (we0),
        .waddr (wptr),
        .wdata (wr_pix),
        .raddr (rd_addr),
        .rdata (q0)
    );

    dp_ram u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (we1),
        .waddr (wptr),
        .wdata (wr_pix),
        .raddr (rd_addr),
        .rdata (q1)
    );

    // Bank select captured alongside the read so a swap shows on the following read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_sel_q <= 1'b0;
        end else begin
            rd_sel_q <= front_sel;
        end
    end

    assign rd_data = rd_sel_q ? q1 : q0;

    // Writer FSM, write pointer, buffer swap and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_WAIT_SOF;
            wptr          <= '0;
            front_sel     <= 1'b0;
            frame_pending <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_SOF: begin
                    if (is_sof) begin
                        state <= ST_LOAD;
                        wptr  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (is_data) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == ADDR_W'(DEPTH - 1)) begin
                            state         <= ST_FULL;
                            frame_pending <= 1'b1;
                        end
                    end else if (is_sof) begin
                        wptr <= '0;
                    end
                end
                ST_FULL: begin
                    if (rd_frame_end) begin
                        front_sel     <= ~front_sel;
                        frame_pending <= 1'b0;
                        if (is_sof) begin
                            // SOF landing on the swap cycle opens the new back bank.
                            state <= ST_LOAD;
                            wptr  <= '0;
                        end else begin
                            state <= ST_WAIT_SOF;
                            if (rx_valid) begin
                                overrun_err <= 1'b1;
                            end
                        end
                    end else if (rx_valid) begin
                        overrun_err <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_WAIT_SOF;
                end
            endcase
        end
    end

endmodule
